// File: rtl/ram_burst_reader.sv
// ram_burst_reader: fetches bursts from the burst RAM and streams them out byte by byte, lowest address first.
module ram_burst_reader #(
  parameter int WIDTH = 8,
  parameter int BURST_LEN = 4,
  parameter int DEPTH = 1024,
  parameter int READ_LATENCY = 2,
  localparam int DEPTH_BITS = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DEPTH_BITS-1:0]      base_address,
  input  logic [DEPTH_BITS:0]        num_bursts,
  output logic                       busy,
  output logic                       done,
  output logic                       read_en,
  output logic [DEPTH_BITS-1:0]      read_address,
  input  logic [BURST_LEN*WIDTH-1:0] read_data_in,
  output logic                       m_valid,
  output logic [WIDTH-1:0]           m_data,
  output logic                       m_last,
  input  logic                       m_ready
);
  localparam int OB = $clog2(BURST_LEN);
  localparam int CW = $clog2(READ_LATENCY + 1);
  localparam int BW = BURST_LEN * WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(READ_LATENCY - 1);
  localparam logic [OB-1:0] IDX_LAST = OB'(BURST_LEN - 1);
  localparam logic [DEPTH_BITS:0] REM_ONE = (DEPTH_BITS + 1)'(1);
  localparam logic [DEPTH_BITS-1:0] ADDR_STEP = DEPTH_BITS'(BURST_LEN);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DONE} state_t;

  state_t state_q, state_d;
  logic [DEPTH_BITS-1:0] addr_q, addr_d;
  logic [DEPTH_BITS:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OB-1:0] idx_q, idx_d;
  logic [BW-1:0] buf_q, buf_d;
  logic unused_ok;

  assign unused_ok = ^base_address[OB-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      buf_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      buf_q <= buf_d;
    end
  end

  // The unpack register shifts left, so the top slice is always the next byte out.
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    buf_d = buf_q;
    case (state_q)
      IDLE: if (start) begin
        addr_d = {base_address[DEPTH_BITS-1:OB], {OB{1'b0}}};
        rem_d = num_bursts;
        state_d = (num_bursts == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: if (cnt_q == CNT_LAST) begin
        buf_d = read_data_in;
        idx_d = '0;
        state_d = DRAIN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      DRAIN: if (m_ready) begin
        buf_d = buf_q << WIDTH;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          addr_d = addr_q + ADDR_STEP;
          rem_d = rem_q - 1'b1;
          state_d = (rem_q == REM_ONE) ? DONE : ISSUE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign read_en = state_q == ISSUE;
  assign read_address = read_en ? addr_q : '0;
  assign m_valid = state_q == DRAIN;
  assign m_data = m_valid ? buf_q[BW-1 -: WIDTH] : '0;
  assign m_last = m_valid && idx_q == IDX_LAST && rem_q == REM_ONE;
  assign busy = state_q == ISSUE || state_q == WAIT || state_q == DRAIN;
  assign done = state_q == DONE;
endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Read-side initiator for the burst RAM. Fetches a run of bursts starting at a base address and delivers the bytes as a valid/ready byte stream in ascending address order. Sits between the burst RAM read port (`read_en` / `read_address` / `read_data_out`) and downstream consumers such as the MNIST layer engines. The RAM's single-byte write port is written by other logic.

## Interface
- `WIDTH`, 8: byte width in bits.
- `BURST_LEN`, 4: bytes per burst. Must be a power of two, ≥2.
- `DEPTH`, 1024: RAM depth in bytes. Must be a power of two. `DEPTH_BITS = $clog2(DEPTH)`.
- `READ_LATENCY`, 2: cycles from the RAM sampling `read_en` to valid `read_data_in`. Must be ≥1.
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; accepted only in IDLE.
- `base_address`  in  DEPTH_BITS  first byte address; the low `$clog2(BURST_LEN)` bits are ignored (forced to 0).
- `num_bursts`  in  DEPTH_BITS+1  number of bursts to read, 0..DEPTH/BURST_LEN.
- `busy`  out  1  high from start acceptance until `done`.
- `done`  out  1  one-cycle completion pulse.
- `read_en`  out  1  to RAM, one-cycle pulse per burst.
- `read_address`  out  DEPTH_BITS  to RAM, burst-aligned.
- `read_data_in`  in  BURST_LEN*WIDTH  from RAM `read_data_out`.
- `m_valid`  out  1  stream byte valid.
- `m_data`  out  WIDTH  stream byte.
- `m_last`  out  1  final byte of the final burst.
- `m_ready`  in  1  consumer accept.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DRAIN, DONE.
- **IDLE**
  - `start=1` latches the aligned `base_address` and `num_bursts`, and sets `busy`.
  - Next state is ISSUE, or DONE if `num_bursts==0`.
- **ISSUE** (1 cycle): drive `read_en=1` with `read_address=addr`, then go to WAIT.
- **WAIT** (READ_LATENCY cycles)
  - A counter tracks the wait.
  - In the last WAIT cycle, `read_data_in` is captured into the unpack register, then go to DRAIN.
- **DRAIN**
  - Emits byte k = `read_data_in[(BURST_LEN-k)*WIDTH-1 -: WIDTH]` for k = 0..BURST_LEN-1. The most significant slice is the lowest address.
  - Advance on `m_valid & m_ready`.
  - After the handshake on byte BURST_LEN-1:
    - `addr <= (addr + BURST_LEN) mod DEPTH` (wraps 1020→0 at defaults) and the remaining-burst count is decremented.
    - If bursts remain, go to ISSUE; otherwise go to DONE.
- **DONE** (1 cycle): `done=1`, `busy=0`, then go to IDLE.
- `start` while not in IDLE is ignored. Latched parameters do not change mid-run.
- Only one burst is outstanding at a time. No prefetch: `read_en` never asserts during WAIT or DRAIN.
- `num_bursts` values greater than DEPTH/BURST_LEN wrap the address repeatedly; no error is flagged.

## Timing
- **Reset values:** `read_en=0`, `read_address=0`, `m_valid=0`, `m_data=0`, `m_last=0`, `busy=0`, `done=0`. State is IDLE.
- **Reset mid-operation:** same values on the next edge. The in-flight burst is discarded.
- **Start acceptance:** `start` is sampled at the edge ending cycle T. `busy=1` and `read_en=1` in cycle T+1 (= C).
- **Data path:** RAM data is valid in cycle C+READ_LATENCY and captured at the end of that cycle. `m_valid` first rises in cycle C+READ_LATENCY+1.
- **Backpressure:** `m_valid` stays high and `m_data`/`m_last` stay stable while `m_ready=0`. The stream has no bubbles within a burst while `m_ready=1`.
- **Throughput:** one burst takes 1 + READ_LATENCY + BURST_LEN cycles at full rate, i.e. 7 cycles at default parameters.
- **Completion:** `done` is asserted in the cycle after the final handshake. `busy` is low in that same cycle. A new `start` is accepted the cycle after `done`.
- **Zero bursts:** `num_bursts=0` gives `done` in cycle T+1, with no `read_en` and no `m_valid`.

## Test plan
- **Single burst:** preload mem[i] = i%256; `base_address`=0, `num_bursts`=1, `m_ready`=1.
  - Exactly one `read_en` pulse at address 0 in cycle C.
  - Bytes 00, 01, 02, 03 in cycles C+3..C+6; `m_last` on 03.
  - `done` in C+7.
- **Byte order:** write AA, BB, CC, DD to addresses 100..103; read with base 100 and 1 burst.
  - Stream is AA, BB, CC, DD.
  - Confirms the MSB slice maps to the lowest address.
- **Wrap:** base 1020, `num_bursts`=2.
  - `read_address` goes 1020 then 0.
  - Stream is FC, FD, FE, FF, 00, 01, 02, 03; `m_last` only on 03.
- **Backpressure:** 4 bursts from 0 with `m_ready` random (~50%).
  - All 16 bytes arrive in order and stay stable while stalled.
  - No `read_en` occurs during DRAIN.
  - `done` follows the last handshake by one cycle.
- **Edge requests:**
  - `num_bursts`=0: `done` in T+1, with no `read_en` and no `m_valid`.
  - `base_address`=102: reads start at 100.
  - `start` pulsed while `busy`: ignored, and the first run completes unchanged.
- **Reset mid-drain:** assert `rst` after 2 bytes of burst 2.
  - All outputs are 0 the next cycle.
  - A fresh start from base 8 streams 08, 09, 0A, 0B correctly.
